pipe_stage_elastic: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer and synchronous flush. It replaces the fixed inter-stage registers (D/E, E/M, M/W) of the five-stage MIPS core. Its payload is NCH channels of WIDTH bits, such as ALUout, data2, IR, pc and pc4. Back-pressure is absorbed without a combinational ready path. Flushed or empty slots present all-zero payload, so IR = 0 decodes as a nop bubble.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_sat_counter.sv | 20 ++
 rtl/pipe_stage_elastic.sv | 118 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage: state encoding,
// default payload geometry and the channel index map of the MIPS stage payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 5;

  // Channel k lives at payload bits [k*WIDTH +: WIDTH].
  localparam int CH_ALU   = 0;
  localparam int CH_DATA2 = 1;
  localparam int CH_IR    = 2;
  localparam int CH_PC    = 3;
  localparam int CH_PC4   = 4;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the stage's stall/bubble statistics.
// Cleared only by reset; holds at all-ones once reached.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main register plus one-entry skid buffer, valid/ready
// handshake with registered in_ready, synchronous flush. Macro PIPE_STAGE_PERF_EN adds stall/bubble counters.
//
// state | meaning
// EMPTY | no live beat; main holds zero
// FULL  | main holds the live output beat
// SKID  | main holds the output beat, skid holds the next one; upstream stalled
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);

  localparam int PW = NCH * WIDTH;

  stage_state_t state, state_nxt;
  logic [PW-1:0] main_q, skid_q;
  logic accept, drain;
  logic load_in, load_skid, promote, clear_main;

  // in_ready is decoded from state only, so out_ready never reaches it combinationally.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != SKID);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_nxt  = state;
    load_in    = 1'b0;
    load_skid  = 1'b0;
    promote    = 1'b0;
    clear_main = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_in   = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (accept && drain) begin
          load_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = SKID;
        end else if (drain) begin
          clear_main = 1'b1;
          state_nxt  = EMPTY;
        end
      end
      SKID: begin
        if (drain) begin
          promote   = 1'b1;
          state_nxt = FULL;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Emptied slots are zeroed so a drained or flushed stage presents IR = 0 (nop).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_in) begin
        main_q <= in_data;
      end else if (promote) begin
        main_q <= skid_q;
      end else if (clear_main) begin
        main_q <= '0;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid),
    .cnt   (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed steps plus random traffic checked
// against a queue-based model of a two-deep FIFO stage.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int W  = 32;
  localparam int N  = 5;
  localparam int PW = W * N;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [PW-1:0] in_data, out_data;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt, bubble_cnt;
  logic          in_ready_s, out_valid_s;
  logic [PW-1:0] out_data_s;
  logic [1:0]    stall_s, bubble_s;
`endif

  pipe_stage_elastic #(
    .WIDTH(W), .NCH(N)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(32)
`endif
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_elastic #(.WIDTH(W), .NCH(N), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .stall_cnt(stall_s), .bubble_cnt(bubble_s)
  );
`endif

  always #5 clk = ~clk;

  logic [PW-1:0] mq[$];
  longint        m_stall, m_bubble;
  int            n_checks, n_pass;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic longint satv(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [PW-1:0] mk(input logic [W-1:0] ir);
    logic [PW-1:0] d;
    d = '0;
    d[CH_ALU*W   +: W] = ir ^ 32'hA5A5_0000;
    d[CH_DATA2*W +: W] = ~ir;
    d[CH_IR*W    +: W] = ir;
    d[CH_PC*W    +: W] = ir << 2;
    d[CH_PC4*W   +: W] = (ir << 2) + 32'd4;
    return d;
  endfunction

  function automatic logic [W-1:0] ir_of(input logic [PW-1:0] d);
    return d[CH_IR*W +: W];
  endfunction

  // Check outputs against the model, then advance one clock and update the model.
  task automatic cycle();
    logic [PW-1:0] exp_data;
    bit drn, acc;
    exp_data = (mq.size() > 0) ? mq[0] : '0;
    chk("out_valid", out_valid, mq.size() > 0);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_data", out_data, exp_data);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", stall_cnt, satv(m_stall, 32));
    chk("bubble_cnt", bubble_cnt, satv(m_bubble, 32));
    chk("stall_cnt_w2", stall_s, satv(m_stall, 2));
    chk("bubble_cnt_w2", bubble_s, satv(m_bubble, 2));
    chk("out_data_w2", out_data_s, exp_data);
`endif
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (mq.size() == 0) m_bubble++;
      else if (!out_ready) m_stall++;
      if (flush) begin
        mq.delete();
      end else begin
        drn = (mq.size() > 0) && out_ready;
        acc = in_valid && (mq.size() < 2);
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [PW-1:0] d, input bit rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; m_stall = 0; m_bubble = 0;
    reset = 1'b1; flush = 1'b0;
    drive(1'b1, mk(32'h99), 1'b0);

    // Reset held two cycles with in_valid asserted.
    @(posedge clk); #1;
    cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, '0);
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_stall", stall_cnt, '0);
    chk("rst_bubble", bubble_cnt, '0);
`endif
    reset = 1'b0;

    // Streaming: one beat per cycle, visible one cycle after accept.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, mk(W'(i)), 1'b1);
      cycle();
      chk("stream_ir", ir_of(out_data), W'(i));
      chk("stream_ready", in_ready, 1'b1);
    end

    // Back-pressure: A, B, C with out_ready low for two cycles after A.
    drive(1'b1, mk(32'h11), 1'b1); cycle();
    chk("bp_a", ir_of(out_data), 32'h11);
    drive(1'b1, mk(32'h22), 1'b0); cycle();
    chk("bp_skid_ready", in_ready, 1'b0);
    chk("bp_hold_a", ir_of(out_data), 32'h11);
    drive(1'b1, mk(32'h33), 1'b0); cycle();
    chk("bp_still_a", ir_of(out_data), 32'h11);
    chk("bp_c_waits", in_ready, 1'b0);
    drive(1'b1, mk(32'h33), 1'b1); cycle();
    chk("bp_b", ir_of(out_data), 32'h22);
    chk("bp_ready_back", in_ready, 1'b1);
    drive(1'b1, mk(32'h33), 1'b1); cycle();
    chk("bp_c", ir_of(out_data), 32'h33);
    drive(1'b0, '0, 1'b1); cycle();
    chk("bp_empty_valid", out_valid, 1'b0);
    chk("bp_empty_data", out_data, '0);

    // Flush while in SKID with D presented.
    drive(1'b1, mk(32'h55), 1'b1); cycle();
    drive(1'b1, mk(32'h66), 1'b0); cycle();
    chk("fl_in_skid", in_ready, 1'b0);
    flush = 1'b1;
    drive(1'b1, mk(32'h44), 1'b0); cycle();
    flush = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_data", out_data, '0);
    chk("fl_ready", in_ready, 1'b1);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_no_d", out_valid, 1'b0);
    end

`ifdef PIPE_STAGE_PERF_EN
    // Counters: one fill cycle (empty), 3 stalls, a drain, 2 idle cycles.
    reset = 1'b1; cycle(); reset = 1'b0;
    drive(1'b1, mk(32'h77), 1'b0); cycle();
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    chk("perf_stall3", stall_cnt, 32'd3);
    chk("perf_bubble", bubble_cnt, 32'd3);
    drive(1'b1, mk(32'h78), 1'b0); cycle();
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    chk("perf_stall8", stall_cnt, 32'd8);
    chk("perf_sat_stall", stall_s, 2'd3);
    chk("perf_sat_bubble", bubble_s, 2'd3);
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("perf_flush_keeps", stall_cnt, 32'd9);
`endif

    // Random traffic including flushes, occasional resets and flush+drain.
    for (int i = 0; i < 400; i++) begin
      logic [PW-1:0] d;
      for (int k = 0; k < N; k++) d[k*W +: W] = $urandom();
      drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
